// File: rtl/seq_pkg.sv
// Shared definitions for the seq_generator / seq_detector family:
// FSM state encoding, default pattern and idle line level.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b0110;
    localparam logic       SEQ_IDLE_BIT        = 1'b1;

endpackage

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first,
// repeat_cnt times, with GAP idle bit-times between repetitions.
module seq_generator
    import seq_pkg::*;
#(
    parameter int unsigned         WIDTH           = 4,
    parameter logic [WIDTH-1:0]    DEFAULT_PATTERN = WIDTH'(SEQ_DEFAULT_PATTERN),
    parameter int unsigned         GAP             = 2,
    parameter logic                IDLE_BIT        = SEQ_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [7:0]       repeat_cnt,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_MAX = (WIDTH > GAP + 1) ? WIDTH : GAP + 1;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] pat_q, pat_nxt;
    logic [CW-1:0]    bit_cnt, bit_nxt;
    logic [7:0]       rep_cnt, rep_nxt;
    logic             x_nxt, xv_nxt, busy_nxt, done_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            sreg    <= DEFAULT_PATTERN;
            pat_q   <= DEFAULT_PATTERN;
            bit_cnt <= '0;
            rep_cnt <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            pat_q   <= pat_nxt;
            bit_cnt <= bit_nxt;
            rep_cnt <= rep_nxt;
            x       <= x_nxt;
            x_valid <= xv_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Outputs are registered from the current state, so each line value
    // appears one cycle after the state that produces it.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        pat_nxt   = pat_q;
        bit_nxt   = bit_cnt;
        rep_nxt   = rep_cnt;
        x_nxt     = IDLE_BIT;
        xv_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg_nxt  = pattern;
                        pat_nxt   = pattern;
                        rep_nxt   = (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
                        bit_nxt   = CW'(WIDTH - 1);
                        state_nxt = S_SEND;
                    end
                end
                S_SEND: begin
                    x_nxt    = sreg[WIDTH-1];
                    xv_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                    sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                    if (bit_cnt == '0) begin
                        if (rep_cnt <= 8'd1) begin
                            state_nxt = S_DONE;
                        end else begin
                            rep_nxt  = rep_cnt - 8'd1;
                            sreg_nxt = pat_q;
                            if (GAP == 0) begin
                                bit_nxt = CW'(WIDTH - 1);
                            end else begin
                                bit_nxt   = CW'(GAP - 1);
                                state_nxt = S_GAP;
                            end
                        end
                    end else begin
                        bit_nxt = bit_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    busy_nxt = 1'b1;
                    if (bit_cnt == '0) begin
                        bit_nxt   = CW'(WIDTH - 1);
                        state_nxt = S_SEND;
                    end else begin
                        bit_nxt = bit_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
